// File: rtl/mips_divider.sv
// Multi-cycle restoring radix-2 integer divider for DIV/DIVU.
// Quotient goes to LO and remainder goes to HI. Each enabled clock
// produces one quotient bit, and the results are held until the next
// accepted start.
module mips_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic               signed_q, signed_d;
  logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;
  logic [WIDTH-1:0]   dvs_raw_q, dvs_raw_d;
  logic [WIDTH-1:0]   dvs_abs_q, dvs_abs_d;
  // Working dividend; quotient bits shift in from the bottom as it empties.
  logic [WIDTH-1:0]   work_q, work_d;
  // One extra bit so that the shifted partial remainder never overflows.
  logic [WIDTH:0]     prem_q, prem_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               trial_ok;
  logic [WIDTH:0]     prem_next;
  logic [WIDTH-1:0]   work_next;
  logic               dvd_neg;
  logic               dvs_neg;

  // One restoring step: the trial subtraction, followed by the sign fix-up of the final results.
  always_comb begin
    shifted   = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
    trial     = {1'b0, shifted} - {2'b00, dvs_abs_q};
    trial_ok  = ~trial[WIDTH+1];
    prem_next = trial_ok ? trial[WIDTH:0] : shifted;
    work_next = {work_q[WIDTH-2:0], trial_ok};
    dvd_neg   = signed_q & dvd_raw_q[WIDTH-1];
    dvs_neg   = signed_q & dvs_raw_q[WIDTH-1];
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d     = state_q;
    signed_d    = signed_q;
    dvd_raw_d   = dvd_raw_q;
    dvs_raw_d   = dvs_raw_q;
    dvs_abs_d   = dvs_abs_q;
    work_d      = work_q;
    prem_d      = prem_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          signed_d  = is_signed;
          dvd_raw_d = dividend;
          dvs_raw_d = divisor;
          // Negating -2^(WIDTH-1) yields the same bit pattern, which is 2^(WIDTH-1) read as unsigned.
          work_d    = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_abs_d = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
          prem_d    = '0;
          count_d   = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      StRun: begin
        prem_d  = prem_next;
        work_d  = work_next;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (dvs_raw_q == '0) begin
            quotient_d  = '1;
            remainder_d = dvd_raw_q;
            dbz_d       = 1'b1;
          end else begin
            quotient_d  = (dvd_neg ^ dvs_neg) ? -work_next : work_next;
            remainder_d = dvd_neg ? -prem_next[WIDTH-1:0] : prem_next[WIDTH-1:0];
            dbz_d       = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State update. Reset takes priority; otherwise the registers advance only on enabled edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      signed_q    <= 1'b0;
      dvd_raw_q   <= '0;
      dvs_raw_q   <= '0;
      dvs_abs_q   <= '0;
      work_q      <= '0;
      prem_q      <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      signed_q    <= signed_d;
      dvd_raw_q   <= dvd_raw_d;
      dvs_raw_q   <= dvs_raw_d;
      dvs_abs_q   <= dvs_abs_d;
      work_q      <= work_d;
      prem_q      <= prem_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/mips_divider.md
Name: mips_divider

Overview:
- Multi-cycle integer divider for the MIPS Harvard CPU; executes DIV/DIVU and produces the quotient (LO) and remainder (HI) for writeback.
- Parametrised in operand width and supports signed and unsigned modes under one interface.
- Uses a restoring radix-2 algorithm: one quotient bit per enabled clock.
- The CPU stalls on busy and captures the results when done pulses.

Parameters:
- WIDTH, 32, operand and result width in bits (any value >= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- clk_enable  input  1  when low, all state is frozen (same semantics as the CPU's clk_enable).
- start  input  1  request a division; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator (rs); sampled with start.
- divisor  input  WIDTH  denominator (rt); sampled with start.
- busy  output  1  high while the division is iterating.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result for LO.
- remainder  output  WIDTH  result for HI.
- div_by_zero  output  1  high with done when the sampled divisor was 0; held with the results.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - reset overrides clk_enable.
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
  - Iteration counter is cleared.
- Gating: with clk_enable=0, no register changes and no input is sampled. Every timing figure below counts enabled edges only.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an enabled edge with start=1: latch is_signed, the raw dividend and the raw divisor.
  - Latch |dividend| and |divisor| (absolute value when is_signed=1, raw value otherwise). Clear the partial remainder and the counter.
  - Go to RUN, busy=1, done=0.
- RUN:
  - Each enabled edge: shift {partial remainder, working dividend} left by 1 and trial-subtract |divisor|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0. Increment the counter.
  - On the WIDTH-th iteration edge: register the final results (with sign fix-up), go to DONE, busy=0, done=1.
- DONE:
  - done=1 for exactly one enabled cycle, then go to IDLE with done=0.
  - start is ignored in DONE.
- Latency: done is high in the cycle following the WIDTH-th enabled edge after the start-sampling edge. busy is high for exactly WIDTH enabled cycles.
- start while busy or in DONE is ignored. The operands are not re-sampled and the running division is unaffected.
- Results:
  - quotient, remainder and div_by_zero hold their last values from DONE until the next accepted start.
  - They change only on the final RUN edge.
- Signed rules (is_signed=1):
  - Quotient truncates toward zero; it is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Signed overflow: -2^(WIDTH-1) / -1 gives quotient = 2^(WIDTH-1) (bit pattern 100..0) and remainder 0. No exception and no flag.
- Divide by zero:
  - Takes the full WIDTH latency.
  - quotient = all ones, remainder = raw latched dividend, div_by_zero=1, in either mode.
- Arithmetic:
  - The partial remainder is WIDTH+1 bits so the trial subtraction never loses the borrow.
  - Absolute value of -2^(WIDTH-1) is treated as the unsigned value 2^(WIDTH-1).
- Reset mid-operation (RUN or DONE): abandon the division immediately and apply the reset values; no done pulse.
- Simultaneous reset and start: reset wins and start is not accepted.

Test Plan:
- DIVU 77/11 (WIDTH=32): start in IDLE -> busy for 32 cycles; done pulses on cycle 33; quotient=7, remainder=0, div_by_zero=0.
- DIVU 0xFFFFFFFF/0x00000002 -> quotient=0x7FFFFFFF, remainder=1; repeat as DIV -> -1/2 gives quotient=0, remainder=0xFFFFFFFF.
- DIV sign cases:
  - -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
  - 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divide by zero: DIVU 0x1234/0 -> after 32 cycles, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1; next start clears div_by_zero on its done.
- Handshake:
  - Pulse start again at RUN cycle 5 with different operands -> ignored; the original result is produced at the original time.
  - Hold clk_enable low for 10 cycles mid-RUN -> done is delayed by exactly 10 cycles and the result is unchanged.
- Reset: assert reset at RUN cycle 16 -> next edge gives busy=0, done=0, quotient=0, remainder=0; no done pulse follows; a fresh DIVU 100/7 then returns quotient=14, remainder=2. Also run WIDTH=8 with 200/3 -> quotient=66, remainder=2, done after 8 cycles.
